platform_scroll_scheduler: RTL
==============================

Name: platform_scroll_scheduler

Overview:
- Once per frame, decides whether the playfield scrolls and by how much. If it does, walks the platform table entry by entry and issues write-backs: each active platform moves down by the scroll amount, and any platform that falls off-screen is respawned at the top with a pseudo-random x.
- Sits between the frame-sync logic, the doodle block (which supplies height and direction and consumes the scroll amount) and the platforms table (read port plus handshaked write port).

Parameters:
- NUM_PLATFORMS, 93, number of table entries; index width 7.
- SCREEN_W, 1024, visible width in pixels.
- SCREEN_H, 768, visible height in lines.
- PLATFORM_W, 100, platform width in pixels.
- SCROLL_LINE, 300, doodle_y threshold; scrolling happens only above this line.
- MAX_SCROLL, 15, per-frame scroll clamp.
- LFSR_SEED, 10'h2A5, reset value of the 10-bit LFSR; must be non-zero.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous reset, active-low.
- frame_start  in  1  single-cycle pulse at start of vertical blanking.
- doodle_y  in  10  current doodle top y.
- doodle_rising  in  1  high while the doodle moves upward.
- rd_idx  out  7  platform table read address.
- rd_x  in  11 signed  x of entry rd_idx; valid 1 cycle after address.
- rd_y  in  11 signed  y of entry rd_idx; valid 1 cycle after address.
- rd_active  in  1  activation bit of entry rd_idx; valid 1 cycle after address.
- wr_valid  out  1  write request.
- wr_ready  in  1  table accepts the write this cycle.
- wr_idx  out  7  write address.
- wr_x  out  11 signed  new x.
- wr_y  out  11 signed  new y.
- wr_active  out  1  new activation bit; always 1 for issued writes.
- scroll_amount  out  4  scroll applied this frame.
- scroll_valid  out  1  1-cycle pulse when the pass completes.
- busy  out  1  high in any state except IDLE.
- frame_overrun  out  1  1-cycle pulse when frame_start arrives while busy.
- score  out  16  running sum of scroll_amount; saturates at 16'hFFFF.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all outputs 0 except rd_idx=0; LFSR=LFSR_SEED; score=0. wr_valid drops immediately, even mid-handshake. A pending write is abandoned, and the table keeps whatever was already accepted.
- LFSR: 10-bit Fibonacci, taps 10,7. Advances exactly once per respawn write, on the accepting cycle.
- States: IDLE, READ, EVAL, WRITE, DONE.
- IDLE:
  - On frame_start, compute s = (doodle_rising && doodle_y < SCROLL_LINE) ? min(SCROLL_LINE - doodle_y, MAX_SCROLL) : 0. Use unsigned arithmetic, at least 10 bits wide.
  - s==0: stay IDLE; scroll_amount := 0; no scroll_valid pulse.
  - s>0: scroll_amount := s; idx := 0; go to READ.
- READ: drive rd_idx=idx; go to EVAL next cycle.
- EVAL: sample rd_x, rd_y, rd_active.
  - Inactive entry: skip; go to the next index (or DONE after the last one).
  - Active entry: ny = rd_y + s, signed 11 bits.
    - ny < SCREEN_H: wr_x=rd_x; wr_y=ny.
    - ny >= SCREEN_H (respawn): wr_y = ny - SCREEN_H; r = LFSR value; wr_x = (r >= SCREEN_W-PLATFORM_W) ? r-(SCREEN_W-PLATFORM_W) : r.
    - Both cases: wr_idx=idx; wr_active=1; go to WRITE.
- WRITE:
  - wr_valid=1. wr_idx, wr_x, wr_y, wr_active hold stable until wr_ready.
  - Acceptance happens on a cycle with wr_valid && wr_ready. On that cycle, drop wr_valid next cycle and go to the next index, or DONE if idx==NUM_PLATFORMS-1.
  - wr_ready high in the same cycle wr_valid rises counts as accepted (zero-wait).
- Next index: idx+1, go to READ.
- DONE: pulse scroll_valid for 1 cycle; score := sat(score + s); go to IDLE.
- Latency: with wr_ready tied high, a pass takes at most 3·NUM_PLATFORMS+1 cycles after frame_start. It must finish within blanking.
- frame_start while busy: ignored (no restart, s unchanged); pulse frame_overrun.
- frame_start and pass completion on the same cycle: the pulse counts as busy and is dropped with frame_overrun.
- Negative rd_y (platform above the screen) is legal and shifts down normally.
- Index NUM_PLATFORMS-1 is the last one read; no access beyond it.

Test Plan:
- No scroll: doodle_y=400, rising=1, frame_start → stays IDLE, wr_valid never rises, scroll_amount=0, no scroll_valid.
- Clamp: doodle_y=250, rising=1, all entries active at y=100, wr_ready=1 → 93 writes with wr_y=115; scroll_valid after ≤280 cycles; scroll_amount=15; score=15.
- Respawn: entry 5 at y=760, x=40, s=10 → write idx 5, wr_y=2; wr_x = LFSR_SEED reduced, i.e. 677; LFSR advances once.
- Backpressure: wr_ready low 7 cycles on entry 0 → wr_valid and payload stable all 7 cycles; exactly one accept; entry 1 follows.
- Inactive skip and overrun: entries 0–89 inactive, second frame_start mid-pass → only 3 writes, frame_overrun pulses once, pass completes normally.
- Async reset mid-WRITE: rst low with wr_valid=1 → wr_valid=0 and busy=0 without a clock edge; score=0; next frame_start begins a fresh pass at idx 0.

Source files
------------

// File: rtl/platform_scroll_scheduler.sv
// Per-frame scroll decision and platform-table walk: moves active platforms down by the
// scroll amount and respawns the ones that fall off the bottom at the top with an LFSR x.
module platform_scroll_scheduler #(
    parameter int         NUM_PLATFORMS = 93,
    parameter int         SCREEN_W      = 1024,
    parameter int         SCREEN_H      = 768,
    parameter int         PLATFORM_W    = 100,
    parameter int         SCROLL_LINE   = 300,
    parameter int         MAX_SCROLL    = 15,
    parameter logic [9:0] LFSR_SEED     = 10'h2A5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_start,
    input  logic [9:0]         doodle_y,
    input  logic               doodle_rising,
    output logic [6:0]         rd_idx,
    input  logic signed [10:0] rd_x,
    input  logic signed [10:0] rd_y,
    input  logic               rd_active,
    output logic               wr_valid,
    input  logic               wr_ready,
    output logic [6:0]         wr_idx,
    output logic signed [10:0] wr_x,
    output logic signed [10:0] wr_y,
    output logic               wr_active,
    output logic [3:0]         scroll_amount,
    output logic               scroll_valid,
    output logic               busy,
    output logic               frame_overrun,
    output logic [15:0]        score
);

    localparam int IDX_W = 7;

    localparam logic [9:0]        SCROLL_LINE_V = 10'(SCROLL_LINE);
    localparam logic [9:0]        MAX_SCROLL_V  = 10'(MAX_SCROLL);
    localparam logic [9:0]        RESPAWN_SPAN  = 10'(SCREEN_W - PLATFORM_W);
    localparam logic signed [10:0] SCREEN_H_V   = 11'(SCREEN_H);
    localparam logic [IDX_W-1:0]  LAST_IDX      = IDX_W'(NUM_PLATFORMS - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        EVAL,
        WRITE,
        DONE
    } state_t;

    // Scroll only while rising above the line, by the distance above it, clamped.
    function automatic logic [3:0] calc_scroll(input logic [9:0] y, input logic rising);
        logic [9:0] diff;
        diff = 10'd0;
        if (rising && (y < SCROLL_LINE_V)) begin
            diff = SCROLL_LINE_V - y;
            if (diff > MAX_SCROLL_V) begin
                diff = MAX_SCROLL_V;
            end
        end
        return diff[3:0];
    endfunction

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [3:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {13'd0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    function automatic logic [9:0] lfsr_next(input logic [9:0] r);
        return {r[8:0], r[9] ^ r[6]};
    endfunction

    // Fold the LFSR value into the range where a whole platform stays on screen.
    function automatic logic signed [10:0] respawn_x(input logic [9:0] r);
        logic [9:0] v;
        v = (r >= RESPAWN_SPAN) ? (r - RESPAWN_SPAN) : r;
        return signed'({1'b0, v});
    endfunction

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [3:0]         scroll_amount_q, scroll_amount_d;
    logic               wr_valid_q, wr_valid_d;
    logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
    logic signed [10:0] wr_x_q, wr_x_d;
    logic signed [10:0] wr_y_q, wr_y_d;
    logic               wr_active_q, wr_active_d;
    logic               respawn_q, respawn_d;
    logic               scroll_valid_q, scroll_valid_d;
    logic               frame_overrun_q, frame_overrun_d;
    logic [15:0]        score_q, score_d;
    logic [9:0]         lfsr_q, lfsr_d;
    logic signed [10:0] ny;
    logic               advance;
    logic [3:0]         s_new;

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        scroll_amount_d = scroll_amount_q;
        wr_valid_d      = wr_valid_q;
        wr_idx_d        = wr_idx_q;
        wr_x_d          = wr_x_q;
        wr_y_d          = wr_y_q;
        wr_active_d     = wr_active_q;
        respawn_d       = respawn_q;
        score_d         = score_q;
        lfsr_d          = lfsr_q;
        scroll_valid_d  = 1'b0;
        frame_overrun_d = frame_start && (state_q != IDLE);
        advance         = 1'b0;
        s_new           = calc_scroll(doodle_y, doodle_rising);
        ny              = rd_y + signed'({7'd0, scroll_amount_q});

        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    scroll_amount_d = s_new;
                    if (s_new != 4'd0) begin
                        idx_d   = '0;
                        state_d = READ;
                    end
                end
            end
            READ: begin
                state_d = EVAL;
            end
            EVAL: begin
                if (!rd_active) begin
                    advance = 1'b1;
                end else begin
                    wr_idx_d    = idx_q;
                    wr_active_d = 1'b1;
                    wr_valid_d  = 1'b1;
                    state_d     = WRITE;
                    if (ny >= SCREEN_H_V) begin
                        wr_y_d    = ny - SCREEN_H_V;
                        wr_x_d    = respawn_x(lfsr_q);
                        respawn_d = 1'b1;
                    end else begin
                        wr_y_d    = ny;
                        wr_x_d    = rd_x;
                        respawn_d = 1'b0;
                    end
                end
            end
            WRITE: begin
                if (wr_ready) begin
                    wr_valid_d = 1'b0;
                    if (respawn_q) begin
                        lfsr_d = lfsr_next(lfsr_q);
                    end
                    advance = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // scroll_valid and the score update land together with the DONE cycle.
        if (advance) begin
            if (idx_q == LAST_IDX) begin
                state_d        = DONE;
                scroll_valid_d = 1'b1;
                score_d        = sat_add16(score_q, scroll_amount_q);
            end else begin
                idx_d   = idx_q + IDX_W'(1);
                state_d = READ;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            idx_q           <= '0;
            scroll_amount_q <= 4'd0;
            wr_valid_q      <= 1'b0;
            wr_idx_q        <= '0;
            wr_x_q          <= '0;
            wr_y_q          <= '0;
            wr_active_q     <= 1'b0;
            respawn_q       <= 1'b0;
            scroll_valid_q  <= 1'b0;
            frame_overrun_q <= 1'b0;
            score_q         <= 16'd0;
            lfsr_q          <= LFSR_SEED;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            scroll_amount_q <= scroll_amount_d;
            wr_valid_q      <= wr_valid_d;
            wr_idx_q        <= wr_idx_d;
            wr_x_q          <= wr_x_d;
            wr_y_q          <= wr_y_d;
            wr_active_q     <= wr_active_d;
            respawn_q       <= respawn_d;
            scroll_valid_q  <= scroll_valid_d;
            frame_overrun_q <= frame_overrun_d;
            score_q         <= score_d;
            lfsr_q          <= lfsr_d;
        end
    end

    assign rd_idx        = idx_q;
    assign wr_valid      = wr_valid_q;
    assign wr_idx        = wr_idx_q;
    assign wr_x          = wr_x_q;
    assign wr_y          = wr_y_q;
    assign wr_active     = wr_active_q;
    assign scroll_amount = scroll_amount_q;
    assign scroll_valid  = scroll_valid_q;
    assign frame_overrun = frame_overrun_q;
    assign score         = score_q;
    assign busy          = (state_q != IDLE);

endmodule
